// File: rtl/qsys_pkg.sv
// Shared definitions for the Qsys perf-eval slave: ID width, request header field
// positions and the request-queue entry layout.
package qsys_pkg;

    localparam int ID_W = 8;
    // Timestamps are stored at a fixed width; only the low CW bits are compared.
    localparam int TS_W = 16;

    typedef struct packed {
        logic [ID_W-1:0] src_id;
        logic [TS_W-1:0] ts;
    } entry_t;

    function automatic int src_pos(input int width);
        return width - 1;
    endfunction

    function automatic int dst_pos(input int width);
        return width - 1 - ID_W;
    endfunction

    function automatic int payload_msb(input int width);
        return width - 1 - 2 * ID_W;
    endfunction

endpackage

// File: rtl/qsys_req_fifo.sv
// Request queue for qsys_slave_pipe: synchronous FIFO with DEPTH entries and
// pointer-plus-wrap-bit occupancy tracking.
module qsys_req_fifo
    import qsys_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push,
    input  logic   pop,
    input  entry_t din,
    output entry_t dout,
    output logic   full,
    output logic   empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    entry_t      mem [DEPTH];
    logic        do_push;
    logic        do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Same index with opposite wrap bits means the write side has lapped the read side.
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign dout  = mem[rd_ptr[AW-1:0]];

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is not reset; an entry is only read after a push has written it.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/qsys_slave_pipe.sv
// Avalon-MM perf-eval traffic responder with a DEPTH-entry request queue and fixed
// minimum read latency. Define QSYS_SLAVE_TRACE_EN for a simulation-only trace.
module qsys_slave_pipe
    import qsys_pkg::*;
#(
    parameter int              WIDTH      = 32,
    parameter logic [ID_W-1:0] ID         = 8'd0,
    parameter int              ADDR_WIDTH = 32,
    parameter int              DEPTH      = 8,
    parameter int              LATENCY    = 2,
    parameter int unsigned     DONE_COUNT = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WIDTH-1:0]      writedata,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  write,
    input  logic                  read,
    output logic                  waitrequest,
    output logic [WIDTH-1:0]      readdata,
    output logic                  readdatavalid,
    output logic                  done
);

    localparam int CW      = $clog2(LATENCY + DEPTH + 1) + 1;
    localparam int RCW     = WIDTH - 2 * ID_W;
    localparam int SRC_MSB = src_pos(WIDTH);
    localparam int DST_MSB = dst_pos(WIDTH);

    logic [CW-1:0]  now_ts;
    logic [CW-1:0]  head_age;
    logic [RCW-1:0] resp_count;
    logic [RCW-1:0] resp_count_inc;
    logic [31:0]    wr_count;
    entry_t         push_entry;
    entry_t         head;
    logic           fifo_full;
    logic           fifo_empty;
    logic           accept;
    logic           push;
    logic           pop;
    logic           wr_accept;
    logic           unused_bits;

    qsys_req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (push_entry),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign waitrequest = fifo_full;

    // NOTE: every always_comb output is assigned on all paths, defaults first, so no latch is inferred.
    always_comb begin
        push_entry        = '0;
        accept            = (read | write) & ~fifo_full;
        push              = accept & read;
        wr_accept         = accept & write & ~read;
        head_age          = now_ts - head.ts[CW-1:0];
        pop               = ~fifo_empty && (head_age >= CW'(LATENCY));
        resp_count_inc    = resp_count + RCW'(1);
        push_entry.src_id = writedata[SRC_MSB -: ID_W];
        push_entry.ts     = TS_W'(now_ts);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            now_ts        <= '0;
            wr_count      <= '0;
            resp_count    <= '0;
            readdata      <= '0;
            readdatavalid <= 1'b0;
            done          <= 1'b0;
        end else begin
            now_ts        <= now_ts + 1'b1;
            readdatavalid <= pop;
            // Follows the registered count, so it clears again if resp_count wraps.
            done          <= (64'(resp_count) > 64'(DONE_COUNT));
            if (wr_accept) wr_count <= wr_count + 32'd1;
            if (pop) begin
                resp_count <= resp_count_inc;
                readdata   <= {ID, head.src_id, resp_count_inc};
            end
        end
    end

    // Address, destination/payload and the write tally have no effect on responses.
    assign unused_bits = ^{address, writedata[DST_MSB:0], wr_count, head.ts};

`ifdef QSYS_SLAVE_TRACE_EN
    always @(posedge clk) begin
        if (rst_n && accept)
            $display("SINK=%d; SRC=%d; time=%d; data=%d; SLAVE;",
                     writedata[SRC_MSB -: ID_W], writedata[DST_MSB -: ID_W], $time,
                     writedata[DST_MSB-ID_W:0]);
        if (rst_n && pop)
            $display("SRC=%d; DST=%d; time=%d; data=%d; SLAVE;",
                     ID, head.src_id, $time, resp_count_inc);
    end
`endif

endmodule
